// File: rtl/spi_master_xfer.sv
// rtl/spi_master_xfer.sv - parametrised SPI master word engine with ready/valid TX and pulsed RX
//
// Purpose: shifts one DATA_W-bit word per TX handshake over SPI in any
// CPOL/CPHA mode, MSB- or LSB-first, with a programmable SCK half-period and
// optional slave-select hold across back-to-back words.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge), asynchronous active-low reset
//   CPOL, CPHA           SCK idle level / sample on trailing edge when 1
//   LSB_FIRST            bit 0 is shifted first when 1
//   CLK_DIV              SCK half-period minus one, in PCLK cycles
//   SS_SEL, HOLD_SS      slave select index / keep SS low into the next word
//   TX_VALID/TX_READY    word handshake, TX_DATA captured on accept
//   RX_VALID, RX_DATA    one-cycle pulse with the received word (held after)
//   BUSY                 word in progress
//   SCK, MOSI, MISO      SPI bus
//   SS_N                 active-low slave selects
module spi_master_xfer #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSB_FIRST,
    input  logic [DIV_W-1:0]  CLK_DIV,
    input  logic [SS_W-1:0]   SS_SEL,
    input  logic              HOLD_SS,
    input  logic              TX_VALID,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_READY,
    output logic              RX_VALID,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              BUSY,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_N
);

    // Tick 1..2*DATA_W toggle SCK; one more tick closes the final half period.
    localparam int TW = $clog2(2 * DATA_W + 2);
    localparam logic [TW-1:0] LAST_EDGE = TW'(2 * DATA_W);
    localparam logic [TW-1:0] END_TICK  = TW'(2 * DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic                hold_q, hold_d;
    logic [DATA_W-1:0]   txw_q, txw_d;
    logic [DATA_W-1:0]   rxsh_q, rxsh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                rdy_en_q;

    logic                timer_done;
    logic [TW-1:0]       tick_n;
    logic [DATA_W-1:0]   txw_r, txw_l;
    logic                tx_ready;
    logic                accept;

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        // Out-of-range indices leave every select deasserted.
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(sel) == i) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Ready is masked for the first cycle out of reset.
    assign tx_ready = rdy_en_q &&
                      ((state_q == S_IDLE) || (state_q == S_TRAIL && timer_done && hold_q));
    assign accept   = TX_VALID && tx_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tick_d     = tick_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        hold_d     = hold_q;
        txw_d      = txw_q;
        rxsh_d     = rxsh_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        timer_done = (cnt_q == div_q);
        tick_n     = tick_q + TW'(1);
        // Bit k of the serial stream sits at either end of a shifted copy.
        txw_r      = txw_q >> tick_n[TW-1:1];
        txw_l      = txw_q << tick_n[TW-1:1];

        case (state_q)
            S_IDLE: begin
                sck_d  = CPOL;
                ss_n_d = '1;
            end
            S_LEAD, S_SHIFT: begin
                if (timer_done) begin
                    cnt_d  = '0;
                    tick_d = tick_n;
                    if (tick_n == END_TICK) begin
                        state_d = S_TRAIL;
                    end else begin
                        state_d = S_SHIFT;
                        sck_d   = ~sck_q;
                        // Odd ticks are leading edges; CPHA picks which edge samples.
                        if (tick_n[0] ^ cpha_q) begin
                            rxsh_d = lsb_q ? {MISO, rxsh_q[DATA_W-1:1]}
                                           : {rxsh_q[DATA_W-2:0], MISO};
                        end else if (tick_n < LAST_EDGE) begin
                            mosi_d = lsb_q ? txw_r[0] : txw_l[DATA_W-1];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_TRAIL: begin
                if (timer_done) begin
                    state_d = S_IDLE;
                    ss_n_d  = '1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_LEAD;
            cnt_d   = '0;
            tick_d  = '0;
            div_d   = CLK_DIV;
            cpha_d  = CPHA;
            lsb_d   = LSB_FIRST;
            hold_d  = HOLD_SS;
            txw_d   = TX_DATA;
            rxsh_d  = '0;
            sck_d   = CPOL;
            ss_n_d  = ss_decode(SS_SEL);
            // CPHA=0 needs the first bit on the wire before the first edge.
            if (!CPHA) begin
                mosi_d = LSB_FIRST ? TX_DATA[0] : TX_DATA[DATA_W-1];
            end
        end

        // Registered look-ahead so the pulse lands on the last TRAIL cycle.
        rx_valid_d = (state_d == S_TRAIL) && (cnt_d == div_d);
        rx_data_d  = rx_valid_d ? rxsh_q : rx_data_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            tick_q     <= '0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            hold_q     <= 1'b0;
            txw_q      <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            hold_q     <= hold_d;
            txw_q      <= txw_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign TX_READY = tx_ready;
    assign RX_VALID = rx_valid_q;
    assign RX_DATA  = rx_data_q;
    assign BUSY     = (state_q != S_IDLE);
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign SS_N     = ss_n_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb/tb_spi_master_xfer.sv - scoreboard bench for spi_master_xfer with behavioural SPI slave
module tb_spi_master_xfer;
    localparam int W   = 8;
    localparam int NS  = 6;
    localparam int DW  = 8;
    localparam int SSW = 3;

    logic           PCLK = 1'b0;
    logic           PRESETn = 1'b1;
    logic           CPOL = 1'b0, CPHA = 1'b0, LSB_FIRST = 1'b0, HOLD_SS = 1'b0, TX_VALID = 1'b0;
    logic [DW-1:0]  CLK_DIV = '0;
    logic [SSW-1:0] SS_SEL = '0;
    logic [W-1:0]   TX_DATA = '0;
    logic           TX_READY, RX_VALID, BUSY, SCK, MOSI, MISO;
    logic [W-1:0]   RX_DATA;
    logic [NS-1:0]  SS_N;

    spi_master_xfer #(.DATA_W(W), .NUM_SS(NS), .DIV_W(DW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .CPOL(CPOL), .CPHA(CPHA), .LSB_FIRST(LSB_FIRST),
        .CLK_DIV(CLK_DIV), .SS_SEL(SS_SEL), .HOLD_SS(HOLD_SS), .TX_VALID(TX_VALID),
        .TX_DATA(TX_DATA), .TX_READY(TX_READY), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .BUSY(BUSY), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [W-1:0]  exp_rx;
        logic [W-1:0]  mosi_bits;   // index n = n-th bit on the wire
        logic [W-1:0]  miso_bits;
        bit            loop;
        bit            cpol;
        bit            cpha;
        int            h;
        logic [NS-1:0] ss;
        int            t_acc;
    } word_t;

    word_t exp_q[$];
    word_t fly_q[$];
    word_t cur;
    int    cmp_cnt = 0, err_cnt = 0, cyc = 0, last_t = -100000;
    int    edges = 0, sidx = 0, rx_cnt = 0, sent = 0;
    bit    have_word = 0, cur_loop = 0;
    logic  sck_prev = 1'b0, mosi_prev = 1'b0, miso_bit = 1'b0;

    assign MISO = (have_word && cur_loop) ? MOSI : miso_bit;

    always @(posedge PCLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serial streams from the SPI rules; the slave always sends MSB-first.
    function automatic word_t model(input logic [W-1:0] tx, input logic [W-1:0] sl, input bit lp,
                                    input bit cp, input bit ch, input bit lsb, input int div,
                                    input int sel);
        word_t w;
        for (int n = 0; n < W; n++) begin
            w.mosi_bits[n] = lsb ? tx[n] : tx[W-1-n];
            w.miso_bits[n] = lp ? w.mosi_bits[n] : sl[W-1-n];
        end
        for (int n = 0; n < W; n++) begin
            w.exp_rx[lsb ? n : W-1-n] = w.miso_bits[n];
        end
        w.loop  = lp;
        w.cpol  = cp;
        w.cpha  = ch;
        w.h     = div + 1;
        w.ss    = {NS{1'b1}};
        if (sel < NS) w.ss[sel] = 1'b0;
        w.t_acc = 0;
        return w;
    endfunction

    always @(negedge PCLK) begin : mon
        int            c;
        bit            eb;
        logic [NS-1:0] ess;
        word_t         w;
        c = cyc;
        if (PRESETn) begin
            eb  = have_word && (c > last_t) && (c <= last_t + (2*W+2)*cur.h);
            ess = eb ? cur.ss : {NS{1'b1}};
            chk("busy", BUSY, eb);
            chk("ss_n", SS_N, ess);
            if (eb && c == last_t + 1) chk("sck_idle_start", SCK, cur.cpol);
            if (eb && c > last_t + 1 && SCK !== sck_prev) begin
                edges++;
                chk("sck_edge_time", c - last_t - 1, edges * cur.h);
                if (SCK == (cur.cpha ? cur.cpol : ~cur.cpol)) begin
                    if (sidx < W) begin
                        chk("mosi_at_sample", mosi_prev, cur.mosi_bits[sidx]);
                        chk("mosi_stable", MOSI, mosi_prev);
                    end
                    sidx++;
                end
            end
            if (RX_VALID) begin
                if (fly_q.size() == 0) begin
                    chk("rx_unexpected", 1, 0);
                end else begin
                    w = fly_q.pop_front();
                    rx_cnt++;
                    chk("rx_data", RX_DATA, w.exp_rx);
                    chk("rx_latency", c - w.t_acc, (2*W+2) * w.h);
                    chk("sck_edges", edges, 2*W);
                    chk("sck_idle_end", SCK, w.cpol);
                end
            end
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    chk("accept_unexpected", 1, 0);
                end else begin
                    cur       = exp_q.pop_front();
                    cur.t_acc = c;
                    fly_q.push_back(cur);
                    last_t    = c;
                    have_word = 1;
                    cur_loop  = cur.loop;
                    edges     = 0;
                    sidx      = 0;
                end
            end
            miso_bit = (have_word && sidx < W) ? cur.miso_bits[sidx] : 1'b0;
        end
        sck_prev  = SCK;
        mosi_prev = MOSI;
    end

    task automatic send(input logic [W-1:0] tx, input logic [W-1:0] sl, input bit lp,
                        input bit cp, input bit ch, input bit lsb, input int div,
                        input int sel, input bit hold, input bit keep);
        bit ok;
        exp_q.push_back(model(tx, sl, lp, cp, ch, lsb, div, sel));
        sent++;
        CPOL = cp; CPHA = ch; LSB_FIRST = lsb; CLK_DIV = DW'(div); SS_SEL = SSW'(sel);
        HOLD_SS = hold; TX_DATA = tx; TX_VALID = 1'b1;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge PCLK);
            if (TX_READY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            exp_q.delete();
            sent--;
        end
        @(posedge PCLK);
        #1;
        if (!keep || !ok) TX_VALID = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge PCLK);
            #1;
            if (fly_q.size() == 0 && exp_q.size() == 0 && !BUSY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        @(posedge PCLK);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        #1 PRESETn = 1'b0;
        #2;
        chk("rst_tx_ready", TX_READY, 0);
        chk("rst_rx_valid", RX_VALID, 0);
        chk("rst_rx_data", RX_DATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_sck", SCK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_ss_n", SS_N, {NS{1'b1}});
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        chk("ready_held_after_release", TX_READY, 0);
        @(posedge PCLK);
        #1;
        chk("ready_first_cycle", TX_READY, 1);

        // Mode 0 loop-back, H=2, select 2
        send(8'hA5, 8'h00, 1, 0, 0, 0, 1, 2, 0, 0);
        wait_done();

        // All four modes against a slave returning 0x3C
        for (int m = 0; m < 4; m++) begin
            send(W'($urandom), 8'h3C, 0, m[1], m[0], 0, 2, m, 0, 0);
            wait_done();
        end

        // LSB-first: 0x01 puts one high bit first; slave 0x80 reads back as 0x01
        send(8'h01, 8'h80, 0, 0, 0, 1, 1, 3, 0, 0);
        wait_done();

        // Held select across three streamed words
        send(8'h11, 8'h00, 1, 0, 0, 0, 1, 1, 1, 1);
        send(8'h22, 8'h00, 1, 0, 0, 0, 1, 1, 1, 1);
        send(8'h33, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0);
        wait_done();

        // Out-of-range selects, fastest SCK
        send(W'($urandom), 8'h96, 0, 0, 1, 0, 0, 7, 0, 0);
        wait_done();
        send(W'($urandom), 8'h5B, 0, 1, 0, 0, 0, 6, 0, 0);
        wait_done();

        // Reset in the middle of SHIFT
        send(8'h5A, 8'hC3, 0, 1, 0, 0, 1, 0, 0, 0);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge PCLK);
            #2;
            if (edges >= 7) begin
                ok = 1;
                break;
            end
        end
        chk("reach_edge_7", ok, 1);
        PRESETn = 1'b0;
        #1;
        chk("midrst_ss_n", SS_N, {NS{1'b1}});
        chk("midrst_sck", SCK, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_rx_valid", RX_VALID, 0);
        chk("midrst_rx_data", RX_DATA, 0);
        chk("midrst_tx_ready", TX_READY, 0);
        sent -= fly_q.size() + exp_q.size();
        fly_q.delete();
        exp_q.delete();
        have_word = 0;
        cur_loop  = 0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        chk("postrst_ready", TX_READY, 1);
        send(8'hE7, 8'h4D, 0, 0, 0, 0, 1, 4, 0, 0);
        wait_done();

        // Randomised words, sometimes streamed back-to-back
        for (int i = 0; i < 24; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom),
                 (i < 23) ? 1'($urandom) : 1'b0);
        end
        wait_done();

        chk("rx_count", rx_cnt, sent);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
